// File: rtl/aes_inv_pkg.sv
// Shared definitions for the AES-128 inverse cipher: FSM states, S-box tables,
// round constants and GF(2^8) helpers over x^8+x^4+x^3+x+1.
package aes_inv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        INIT  = 3'd2,
        ROUND = 3'd3,
        FINAL = 3'd4
    } state_t;

    // Element 0 sits in the most significant byte, so SBOX[x] is the entry for x.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Indexed by the round counter; entries 0 and 11..15 are never used.
    localparam logic [0:15][7:0] RCON = 128'h0001020408102040801b360000000000;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_top_key_step.sv
// Single AES-128 key-schedule step, forward (rk_r -> rk_r+1) or inverse
// (rk_r -> rk_r-1). Both directions share one set of four S-boxes.
module aes_key_step
    import aes_inv_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    input  logic         inverse,
    output logic [127:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] last_word, rot_word, sub_word, temp;
    logic [31:0] f0, f1, f2, f3;

    assign {w0, w1, w2, w3} = key_in;

    // The inverse step recovers the previous last word as w3^w2 before the
    // RotWord/SubWord, so the S-boxes just see a different input.
    assign last_word = inverse ? (w3 ^ w2) : w3;
    assign rot_word  = {last_word[23:0], last_word[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub
            assign sub_word[gi*8 +: 8] = SBOX[rot_word[gi*8 +: 8]];
        end
    endgenerate

    assign temp = sub_word ^ {rcon, 24'h000000};

    assign f0 = w0 ^ temp;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign key_out = inverse ? {w0 ^ temp, w1 ^ w0, w2 ^ w1, w3 ^ w2}
                             : {f0, f1, f2, f3};

endmodule

// File: rtl/aes_inv_top.sv
// Iterative AES-128 decryptor: expands the key forward to rk10, then walks the
// schedule backwards one step per round while applying the inverse rounds.
module aes_inv_top
    import aes_inv_pkg::*;
(
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    state_t       fsm;
    logic [127:0] blk;
    logic [127:0] rkey;
    logic [3:0]   round_cnt;

    logic [127:0] inv_sub;
    logic [127:0] added;
    logic [127:0] mixed;
    logic [127:0] key_next;

    // Only KEXP runs the schedule forward; INIT and ROUND step it backwards.
    aes_key_step u_key_step (
        .key_in  (rkey),
        .rcon    (RCON[round_cnt]),
        .inverse (fsm != KEXP),
        .key_out (key_next)
    );

    // Byte i lives at bits [127-8i -: 8]; row = i%4, column = i/4.
    // InvShiftRows is folded into the S-box addressing of each lane.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_lane
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
            localparam int B1  = 4 * COL + (ROW + 1) % 4;
            localparam int B2  = 4 * COL + (ROW + 2) % 4;
            localparam int B3  = 4 * COL + (ROW + 3) % 4;

            assign inv_sub[127-8*gi -: 8] = INV_SBOX[blk[127-8*SRC -: 8]];

            assign mixed[127-8*gi -: 8] = gf_mul(added[127-8*gi -: 8], 8'h0e)
                                        ^ gf_mul(added[127-8*B1 -: 8], 8'h0b)
                                        ^ gf_mul(added[127-8*B2 -: 8], 8'h0d)
                                        ^ gf_mul(added[127-8*B3 -: 8], 8'h09);
        end
    endgenerate

    // The same InvSubBytes/AddRoundKey result feeds both ROUND and FINAL.
    assign added = inv_sub ^ rkey;

    // Control FSM, round counter, state/key registers and registered outputs.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm                <= IDLE;
            blk                <= '0;
            rkey               <= '0;
            round_cnt          <= 4'd0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
        end else begin
            AES_data_out_valid <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (AES_en) begin
                        blk       <= AES_data_in;
                        rkey      <= AES_key_in;
                        round_cnt <= 4'd1;
                        fsm       <= KEXP;
                    end
                end
                KEXP: begin
                    rkey <= key_next;
                    // Counter stays at 10 so INIT regenerates rk9 with Rcon[10].
                    if (round_cnt == 4'd10) begin
                        fsm <= INIT;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                INIT: begin
                    blk       <= blk ^ rkey;
                    rkey      <= key_next;
                    round_cnt <= round_cnt - 4'd1;
                    fsm       <= ROUND;
                end
                ROUND: begin
                    blk       <= mixed;
                    rkey      <= key_next;
                    round_cnt <= round_cnt - 4'd1;
                    if (round_cnt == 4'd1) begin
                        fsm <= FINAL;
                    end
                end
                FINAL: begin
                    AES_data_out       <= added;
                    AES_data_out_valid <= 1'b1;
                    fsm                <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_top.sv
// Directed and round-trip checks for the AES-128 inverse cipher.
module tb_aes_inv_top;
    import aes_inv_pkg::*;

    logic         AES_clk = 1'b0;
    logic         AES_rst_n;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    always #5 AES_clk = ~AES_clk;

    aes_inv_top dut (
        .AES_clk            (AES_clk),
        .AES_rst_n          (AES_rst_n),
        .AES_en             (AES_en),
        .AES_data_in        (AES_data_in),
        .AES_key_in         (AES_key_in),
        .AES_data_out       (AES_data_out),
        .AES_data_out_valid (AES_data_out_valid)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward AES-128 cipher, used to build ciphertexts for the round trips.
    function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] s, t, rk;
        logic [31:0]  w, n0, n1, n2, n3;
        logic [7:0]   a0, a1, a2, a3;
        int           src;
        rk = key;
        s  = pt ^ rk;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) begin
                src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
                t[127-8*i -: 8] = SBOX[s[127-8*src -: 8]];
            end
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        a0 = t[127-8*(4*c + r) -: 8];
                        a1 = t[127-8*(4*c + (r+1)%4) -: 8];
                        a2 = t[127-8*(4*c + (r+2)%4) -: 8];
                        a3 = t[127-8*(4*c + (r+3)%4) -: 8];
                        s[127-8*(4*c + r) -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    end
                end
            end else begin
                s = t;
            end
            w = {rk[23:0], rk[31:24]};
            w = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
            w = w ^ {RCON[rnd], 24'h000000};
            n0 = rk[127:96] ^ w;
            n1 = rk[95:64] ^ n0;
            n2 = rk[63:32] ^ n1;
            n3 = rk[31:0] ^ n2;
            rk = {n0, n1, n2, n3};
            s  = s ^ rk;
        end
        return s;
    endfunction

    // Pulse AES_en for one cycle; returns at the falling edge just after T0.
    task automatic start_op(input logic [127:0] key, input logic [127:0] ct);
        @(negedge AES_clk);
        AES_en      = 1'b1;
        AES_key_in  = key;
        AES_data_in = ct;
        @(negedge AES_clk);
        AES_en = 1'b0;
    endtask

    // Counts falling edges until valid is seen, bounded by limit.
    task automatic wait_valid(input int limit, output int lat);
        lat = 0;
        while (AES_data_out_valid !== 1'b1 && lat < limit) begin
            @(negedge AES_clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        AES_rst_n   = 1'b0;
        AES_en      = 1'b0;
        AES_data_in = '0;
        AES_key_in  = '0;
        repeat (2) @(negedge AES_clk);
        checks++;
        if (AES_data_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_data_out got %h want %h", AES_data_out, 128'h0);
        end
        checks++;
        if (AES_data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", AES_data_out_valid);
        end
        AES_rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_vector1;
        int lat;
        start_op(K1, C1);
        wait_valid(40, lat);
        $display("op key=%h ct=%h out=%h lat=%0d", K1, C1, AES_data_out, lat);
        checks++;
        if (lat != 21) begin
            errors++;
            $display("FAIL v1_latency got %0d want 21", lat);
        end
        checks++;
        if (AES_data_out !== P1) begin
            errors++;
            $display("FAIL v1_data got %h want %h", AES_data_out, P1);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge AES_clk);
            checks++;
            if (AES_data_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL v1_valid_drop cycle %0d got %b want 0", i, AES_data_out_valid);
            end
            checks++;
            if (AES_data_out !== P1) begin
                errors++;
                $display("FAIL v1_hold cycle %0d got %h want %h", i, AES_data_out, P1);
            end
        end
    endtask

    task automatic test_vector2;
        int lat;
        start_op(K2, C2);
        wait_valid(40, lat);
        $display("op key=%h ct=%h out=%h lat=%0d", K2, C2, AES_data_out, lat);
        checks++;
        if (lat != 21) begin
            errors++;
            $display("FAIL v2_latency got %0d want 21", lat);
        end
        checks++;
        if (AES_data_out !== P2) begin
            errors++;
            $display("FAIL v2_data got %h want %h", AES_data_out, P2);
        end
    endtask

    task automatic test_back_to_back;
        int lat1;
        int lat2;
        @(negedge AES_clk);
        AES_en      = 1'b1;
        AES_key_in  = K1;
        AES_data_in = C1;
        @(negedge AES_clk);
        wait_valid(40, lat1);
        $display("op b2b first out=%h lat=%0d", AES_data_out, lat1);
        checks++;
        if (lat1 != 21) begin
            errors++;
            $display("FAIL b2b_first_latency got %0d want 21", lat1);
        end
        checks++;
        if (AES_data_out !== P1) begin
            errors++;
            $display("FAIL b2b_first_data got %h want %h", AES_data_out, P1);
        end
        AES_key_in  = K2;
        AES_data_in = C2;
        @(negedge AES_clk);
        lat2 = 1;
        while (AES_data_out_valid !== 1'b1 && lat2 < 40) begin
            @(negedge AES_clk);
            lat2++;
        end
        AES_en = 1'b0;
        $display("op b2b second out=%h spacing=%0d", AES_data_out, lat2);
        checks++;
        if (lat2 != 22) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want 22", lat2);
        end
        checks++;
        if (AES_data_out !== P2) begin
            errors++;
            $display("FAIL b2b_second_data got %h want %h", AES_data_out, P2);
        end
    endtask

    task automatic test_ignore_inputs;
        int lat;
        start_op(K1, C1);
        lat = 0;
        while (AES_data_out_valid !== 1'b1 && lat < 40) begin
            AES_data_in = {$urandom, $urandom, $urandom, $urandom};
            AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
            AES_en      = 1'($urandom_range(0, 1));
            @(negedge AES_clk);
            lat++;
        end
        AES_en = 1'b0;
        $display("op busy_toggle out=%h lat=%0d", AES_data_out, lat);
        checks++;
        if (lat != 21) begin
            errors++;
            $display("FAIL busy_latency got %0d want 21", lat);
        end
        checks++;
        if (AES_data_out !== P1) begin
            errors++;
            $display("FAIL busy_data got %h want %h", AES_data_out, P1);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        int seen;
        start_op(K2, C2);
        repeat (9) @(negedge AES_clk);
        #2;
        AES_rst_n = 1'b0;
        #1;
        checks++;
        if (AES_data_out !== 128'h0) begin
            errors++;
            $display("FAIL abort_data got %h want 0", AES_data_out);
        end
        checks++;
        if (AES_data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_valid got %b want 0", AES_data_out_valid);
        end
        repeat (2) @(negedge AES_clk);
        AES_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge AES_clk);
            if (AES_data_out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_pulse got %0d pulses want 0", seen);
        end
        // Restart with AES_en already high at the release, so the first edge samples it.
        AES_rst_n = 1'b0;
        @(negedge AES_clk);
        AES_rst_n   = 1'b1;
        AES_en      = 1'b1;
        AES_key_in  = K1;
        AES_data_in = C1;
        @(negedge AES_clk);
        AES_en = 1'b0;
        wait_valid(40, lat);
        $display("op restart out=%h lat=%0d", AES_data_out, lat);
        checks++;
        if (lat != 21) begin
            errors++;
            $display("FAIL restart_latency got %0d want 21", lat);
        end
        checks++;
        if (AES_data_out !== P1) begin
            errors++;
            $display("FAIL restart_data got %h want %h", AES_data_out, P1);
        end
    endtask

    task automatic test_round_trip;
        logic [127:0] key, pt, ct;
        int lat;
        for (int n = 0; n < 100; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            ct  = enc(key, pt);
            start_op(key, ct);
            wait_valid(40, lat);
            $display("op rt%0d key=%h pt=%h out=%h lat=%0d", n, key, pt, AES_data_out, lat);
            checks++;
            if (AES_data_out !== pt || lat != 21) begin
                errors++;
                $display("FAIL round_trip_%0d got %h lat %0d want %h lat 21", n, AES_data_out, lat, pt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vector1();
        test_vector2();
        test_back_to_back();
        test_ignore_inputs();
        test_reset_abort();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
